// File: rtl/sys_pkg.sv
// Shared definitions for the front-panel key scanner: per-key FSM state
// encoding, default timing constants and a small sizing helper.
package sys_pkg;

  // Per-key FSM states (kept as plain 2-bit constants for legacy users)
  localparam logic [1:0] KS_IDLE    = 2'd0;
  localparam logic [1:0] KS_PRESSED = 2'd1;
  localparam logic [1:0] KS_LONG    = 2'd2;

  // Default timing, in ticks of the corresponding timebase strobe
  localparam int NKEY_DEF   = 4;
  localparam int DEB_MS_DEF = 20;
  localparam int LONG_T_DEF = 32;
  localparam int REP_T_DEF  = 4;

  // Larger of two integers, used to size a counter shared by two roles
  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One front-panel key: 2-flop synchroniser, debounce counter on tick1ms and
// a press/long/repeat classifier on tick32ms. All strobes are registered and
// one clk cycle wide.
// Optional feature: define KEY_REPEAT_EN to generate auto-repeat strobes in
// the LONG state; otherwise key_rep is tied low and no repeat logic exists.
module key_debounce
  import sys_pkg::*;
#(
  parameter int DEB_MS = DEB_MS_DEF,
  parameter int LONG_T = LONG_T_DEF,
  parameter int REP_T  = REP_T_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick1ms,
  input  logic tick32ms,
  input  logic key_n,
  output logic key_lvl,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_rep
);

  localparam int DW = $clog2(DEB_MS + 1);
  localparam int HW = $clog2(max_i(LONG_T, REP_T) + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_T - 1);
  localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_T);
`ifdef KEY_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_T - 1);
`endif

  logic          sync1;
  logic          sync2;
  logic          sk;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [1:0]    state;
  logic          flip;
  logic          rise;
  logic          fall;

  // Bring the raw asynchronous key into the clk domain; idles as released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign sk = ~sync2;

  // The debounced level changes on the tick that completes the stable run;
  // the same condition drives the edge strobes and the FSM so they all line up.
  assign flip = tick1ms && (sk != key_lvl) && (dcnt == DEB_LAST);
  assign rise = flip & sk;
  assign fall = flip & ~sk;

  // Debounce counter: any disagreement that is not yet stable long enough
  // keeps counting; agreement (including a bounce back) clears the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt        <= '0;
      key_lvl     <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= rise;
      key_release <= fall;
      if (sk == key_lvl) begin
        dcnt <= '0;
      end else if (tick1ms) begin
        if (dcnt == DEB_LAST) begin
          key_lvl <= sk;
          dcnt    <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  // Hold classifier. A release always wins over a long/repeat threshold
  // landing in the same cycle; hcnt doubles as the repeat counter in LONG.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= KS_IDLE;
      hcnt     <= '0;
      key_long <= 1'b0;
`ifdef KEY_REPEAT_EN
      key_rep  <= 1'b0;
`endif
    end else begin
      key_long <= 1'b0;
`ifdef KEY_REPEAT_EN
      key_rep  <= 1'b0;
`endif
      if (fall) begin
        state <= KS_IDLE;
        hcnt  <= '0;
      end else begin
        case (state)
          KS_IDLE: begin
            if (rise) begin
              state <= KS_PRESSED;
              hcnt  <= '0;
            end
          end
          KS_PRESSED: begin
            if (tick32ms) begin
              if (hcnt == LONG_LAST) begin
                key_long <= 1'b1;
                state    <= KS_LONG;
                hcnt     <= '0;
              end else if (hcnt != LONG_SAT) begin
                hcnt <= hcnt + 1'b1;
              end
            end
          end
          KS_LONG: begin
`ifdef KEY_REPEAT_EN
            if (tick32ms) begin
              if (hcnt == REP_LAST) begin
                key_rep <= 1'b1;
                hcnt    <= '0;
              end else begin
                hcnt <= hcnt + 1'b1;
              end
            end
`endif
          end
          default: begin
            state <= KS_IDLE;
            hcnt  <= '0;
          end
        endcase
      end
    end
  end

`ifndef KEY_REPEAT_EN
  assign key_rep = 1'b0;
`endif

endmodule

// File: rtl/key_scan.sv
// Front-panel key scanner: debounces NKEY active-low keys and emits press,
// release, long-press and (with KEY_REPEAT_EN defined) auto-repeat strobes.
// The ticks come from the 1 ms / 32 ms timebase as single-cycle pulses.
module key_scan
  import sys_pkg::*;
#(
  parameter int NKEY   = NKEY_DEF,
  parameter int DEB_MS = DEB_MS_DEF,
  parameter int LONG_T = LONG_T_DEF,
  parameter int REP_T  = REP_T_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick1ms,
  input  logic            tick32ms,
  input  logic [NKEY-1:0] key_n,
  output logic [NKEY-1:0] key_lvl,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [NKEY-1:0] key_long,
  output logic [NKEY-1:0] key_rep
);

  // Keys are fully independent; one scanner per key shares only the ticks
  for (genvar i = 0; i < NKEY; i++) begin : g_key
    key_debounce #(
      .DEB_MS (DEB_MS),
      .LONG_T (LONG_T),
      .REP_T  (REP_T)
    ) u_key (
      .clk         (clk),
      .rst         (rst),
      .tick1ms     (tick1ms),
      .tick32ms    (tick32ms),
      .key_n       (key_n[i]),
      .key_lvl     (key_lvl[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i]),
      .key_rep     (key_rep[i])
    );
  end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan (NKEY=4, DEB_MS=20, LONG_T=32, REP_T=4).
// Time is compressed: one tick1ms every 8 clk cycles, tick32ms every 256.
`timescale 1ns/1ps
module tb_key_scan;

  localparam int NKEY   = 4;
  localparam int DEB_MS = 20;
  localparam int LONG_T = 32;
  localparam int REP_T  = 4;
  localparam int MS     = 8;
  localparam int T32    = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick1ms;
  logic        tick32ms;
  logic [3:0]  key_n = 4'hF;
  logic [3:0]  key_lvl;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic [3:0]  key_long;
  logic [3:0]  key_rep;
  logic [31:0] cyc = 32'd0;

  int compared   = 0;
  int mismatched = 0;
  int press_cnt[4]   = '{default: 0};
  int release_cnt[4] = '{default: 0};
  int long_cnt[4]    = '{default: 0};
  int rep_cnt[4]     = '{default: 0};
  int press_at[4]    = '{default: 0};
  int release_at[4]  = '{default: 0};
  int long_at[4]     = '{default: 0};
  int rep_at[4]      = '{default: 0};
  int all_press      = 0;

  key_scan #(
    .NKEY   (NKEY),
    .DEB_MS (DEB_MS),
    .LONG_T (LONG_T),
    .REP_T  (REP_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick1ms     (tick1ms),
    .tick32ms    (tick32ms),
    .key_n       (key_n),
    .key_lvl     (key_lvl),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_rep     (key_rep)
  );

  always #5 clk = ~clk;

  // Timebase: the DUT samples tick1ms at posedge k when k%8==7, tick32ms when k%256==255
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign tick1ms  = (cyc[2:0] == 3'd7);
  assign tick32ms = (cyc[7:0] == 8'hFF);

  // Strobe monitor: records count and the posedge index of each strobe
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (key_press[i])   begin press_cnt[i]++;   press_at[i]   = int'(cyc) - 1; end
        if (key_release[i]) begin release_cnt[i]++; release_at[i] = int'(cyc) - 1; end
        if (key_long[i])    begin long_cnt[i]++;    long_at[i]    = int'(cyc) - 1; end
        if (key_rep[i])     begin rep_cnt[i]++;     rep_at[i]     = int'(cyc) - 1; end
      end
      if (key_press == 4'hF) all_press++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: changes one key; j is the posedge just passed
  task automatic drive(input int idx, input logic v, output int j);
    key_n[idx] = v;
    j = int'(cyc) - 1;
  endtask

  function automatic int first_tick(input int k, input int per);
    int m = k;
    while (m % per != per - 1) m++;
    return m;
  endfunction

  // Input changed after posedge j: sk differs from posedge j+3, DEB_MS ticks later lvl flips
  function automatic int deb_exp(input int j);
    return first_tick(j + 3, MS) + (DEB_MS - 1) * MS;
  endfunction

  // Level rose at posedge p: the LONG_T-th tick32ms after p fires key_long
  function automatic int long_exp(input int p);
    return first_tick(p + 1, T32) + (LONG_T - 1) * T32;
  endfunction

  initial begin
    int j, jr, e, p, le, r, nrep, last, s_press, s_rel, s_all;

    // Reset state
    rst = 1'b0;
    step(4);
    check("rst_lvl", int'(key_lvl), 0);
    check("rst_strobes", int'({key_press, key_release, key_long, key_rep}), 0);
    rst = 1'b1;
    step(4);
    check("post_rst_lvl", int'(key_lvl), 0);

    // 1. Clean press and release on key0
    drive(0, 1'b0, j);
    e = deb_exp(j);
    step(25 * MS);
    check("t1_lvl_pressed", int'(key_lvl[0]), 1);
    check("t1_press_cnt", press_cnt[0], 1);
    check("t1_press_at", press_at[0], e);
    drive(0, 1'b1, j);
    e = deb_exp(j);
    step(25 * MS);
    check("t1_lvl_released", int'(key_lvl[0]), 0);
    check("t1_release_cnt", release_cnt[0], 1);
    check("t1_release_at", release_at[0], e);
    check("t1_long_cnt", long_cnt[0], 0);

    // 2. Key1 bounces every 5 ms for 40 ms, ending pressed
    for (int n = 0; n < 9; n++) begin
      drive(1, (n % 2 == 1), j);
      if (n < 8) step(5 * MS);
    end
    check("t2_no_press_in_bounce", press_cnt[1], 0);
    check("t2_no_release_in_bounce", release_cnt[1], 0);
    e = deb_exp(j);
    step(25 * MS);
    check("t2_press_cnt", press_cnt[1], 1);
    check("t2_press_at", press_at[1], e);
    drive(1, 1'b1, j);
    step(25 * MS);
    check("t2_release_cnt", release_cnt[1], 1);

    // 3. Key2 held 1.4 s: long press, then repeats every REP_T*32 ms when enabled
    drive(2, 1'b0, j);
    p  = deb_exp(j);
    le = long_exp(p);
    step(1400 * MS);
    drive(2, 1'b1, jr);
    r = deb_exp(jr);
    step(25 * MS);
    check("t3_press_at", press_at[2], p);
    check("t3_long_cnt", long_cnt[2], 1);
    check("t3_long_at", long_at[2], le);
    check("t3_release_at", release_at[2], r);
    nrep = 0;
    last = 0;
    for (int t = le + REP_T * T32; t < r; t += REP_T * T32) begin
      nrep++;
      last = t;
    end
`ifdef KEY_REPEAT_EN
    check("t3_rep_cnt", rep_cnt[2], nrep);
    check("t3_rep_last_at", rep_at[2], last);
`else
    check("t3_rep_cnt", rep_cnt[2], 0);
`endif

    // 4. Key3 release lands exactly on the long-press threshold tick32ms
    drive(3, 1'b0, j);
    p  = deb_exp(j);
    le = long_exp(p);
    while (int'(cyc) - 1 < le - 155) step(1);
    drive(3, 1'b1, jr);
    step(25 * MS);
    check("t4_press_cnt", press_cnt[3], 1);
    check("t4_release_cnt", release_cnt[3], 1);
    check("t4_release_at", release_at[3], le);
    check("t4_long_cnt", long_cnt[3], 0);
    check("t4_rep_cnt", rep_cnt[3], 0);

    // 5. Reset mid-hold on key0, then a fresh debounce with the key still held
    s_press = press_cnt[0];
    s_rel   = release_cnt[0];
    drive(0, 1'b0, j);
    e = deb_exp(j);
    step(30 * MS);
    check("t5_press_at", press_at[0], e);
    rst = 1'b0;
    #1;
    check("t5_rst_lvl", int'(key_lvl), 0);
    check("t5_rst_strobes", int'({key_press, key_release, key_long, key_rep}), 0);
    step(3);
    rst = 1'b1;
    j = int'(cyc) - 1;
    e = deb_exp(j);
    step(25 * MS);
    check("t5_press_cnt", press_cnt[0], s_press + 2);
    check("t5_press_after_rst_at", press_at[0], e);
    check("t5_no_release", release_cnt[0], s_rel);
    check("t5_lvl", int'(key_lvl[0]), 1);

    // 6. All keys pressed in the same cycle
    drive(0, 1'b1, j);
    step(25 * MS);
    s_all = all_press;
    key_n = 4'h0;
    j = int'(cyc) - 1;
    e = deb_exp(j);
    step(25 * MS);
    check("t6_all_press_once", all_press, s_all + 1);
    for (int i = 0; i < 4; i++) check($sformatf("t6_press_at_%0d", i), press_at[i], e);
    check("t6_lvl_all", int'(key_lvl), 15);
    key_n = 4'hF;
    step(25 * MS);
    check("t6_lvl_none", int'(key_lvl), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
